wb_slave_mem: RTL and testbench
===============================

# wb_slave_mem

Wishbone B4 classic-cycle slave with byte-addressable memory, sitting directly downstream of the master-to-slave interconnect. It consumes the slave-side signals (CYC/STB/WE/ADR/DAT/SEL/TAGs) and returns DAT_O/TGD_O with ACK_O or ERR_O after a programmable number of wait states. It is the default memory target for the Wishbone UVM environment, so its response timing is fully deterministic.

## Interface
- ADR_WIDTH, 32, address bus width
- DAT_WIDTH, 64, data bus width; must be a multiple of 8
- SEL_WIDTH, DAT_WIDTH/8, byte-select width (derived; do not override)
- TG_WIDTH, 8, width of TGA/TGC/TGD tags
- MEM_DEPTH, 256, number of DAT_WIDTH words
- BASE_ADDR, 0, byte address of word 0
- WAIT_STATES, 1, extra cycles before the response (0..15)

Ports:
- CLK_I  in  1  clock; all logic on the rising edge
- RST_I  in  1  reset; asynchronous, active-high
- CYC_I, STB_I, WE_I, LOCK_I  in  1 each  Wishbone cycle, strobe, write enable, lock
- ADR_I  in  ADR_WIDTH  byte address
- DAT_I  in  DAT_WIDTH  write data
- SEL_I  in  SEL_WIDTH  byte lane enables
- TGA_I, TGC_I, TGD_I  in  TG_WIDTH each  address, cycle and data tags
- DAT_O  out  DAT_WIDTH  read data
- TGD_O  out  TG_WIDTH  data tag returned with the response
- ACK_O, ERR_O, RTY_O  out  1 each  termination signals

## Operation
- Reset values: ACK_O=0, ERR_O=0, RTY_O=0, DAT_O=0, TGD_O=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- RTY_O is constant 0. LOCK_I, TGA_I and TGC_I are accepted and ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on CYC_I&STB_I, capture ADR/WE/DAT/SEL/TGD into request registers.
  - Request is bad if ADR_I < BASE_ADDR, or ADR_I >= BASE_ADDR + MEM_DEPTH*SEL_WIDTH, or ADR_I[log2(SEL_WIDTH)-1:0] != 0.
  - Bad request: go to RESP with ERR pending.
  - Good request with WAIT_STATES=0: go to RESP.
  - Otherwise go to WAIT, counter=WAIT_STATES.
- WAIT: decrement the counter; go to RESP when the counter reaches 1. If CYC_I or STB_I is low, abort to IDLE with no memory write and no response.
- RESP (exactly one cycle): assert ACK_O for a good request, or ERR_O for a bad one; never both. Next state is always IDLE.
  - Good write: for each byte lane i with SEL=1, mem[word][8i+7:8i] = DAT byte i. The write commits on the edge entering RESP. Lanes with SEL=0 are unchanged.
  - Good read: DAT_O = mem[word] (all lanes, regardless of SEL), registered with ACK_O.
  - TGD_O = captured TGD for every response, including ERR.
- Word index = (ADR - BASE_ADDR) >> log2(SEL_WIDTH).
- DAT_O holds its value between reads. ERR responses and writes do not change DAT_O.
- If RST_I asserts at any point, all outputs clear immediately and any pending write is dropped.

## Timing
- A request sampled at edge N produces a response asserted during cycle N+1+WAIT_STATES. ERR responses always come at N+1.
- Response lasts exactly one cycle. After the response, the FSM spends one cycle in IDLE before it can accept a new request, so there is at least 2 cycles per transfer.
- A request held across RESP is sampled again in IDLE as a new transfer. Masters must drop STB_I after sampling ACK_O.
- A read immediately following a write to the same word returns the new data.

## Structure
- Package wb_slave_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the function for the log2 of SEL_WIDTH;
  - the default parameter constants.
- Sub-module wb_slave_mem_array: single-port, byte-enable RAM of MEM_DEPTH×DAT_WIDTH with a synchronous write and registered read. It is instantiated once. The FSM, address check, tag capture and response registers stay in the top level.

## Test plan
- Reset: hold RST_I for 3 cycles, then release. All outputs read 0, with no response to a CYC_I=1, STB_I=0 idle.
- Full write then read: WAIT_STATES=1. Write 0x1122334455667788 to 0x10 with SEL=0xFF, then read 0x10. Required response: ACK in the second cycle after each request, DAT_O=0x1122334455667788, TGD_O echoes 0x5A.
- Byte-lane write: write 0xFFFF_FFFF_FFFF_FFFF to 0x10 with SEL=0x0F, then read 0x10. Required response: DAT_O=0x11223344FFFFFFFF.
- Errors:
  - Misaligned address 0x13 gives ERR_O one cycle after the request, with no ACK.
  - Out-of-range address 0x800 (MEM_DEPTH=256) gives ERR_O, and memory is unchanged.
- Abort and wait states: WAIT_STATES=3. Drop CYC_I in the second WAIT cycle of a write to 0x20. Required response: no ACK, and a later read of 0x20 returns the old data. Back-to-back reads take 5 cycles each.
- Reset mid-transfer: assert RST_I while in WAIT during a write. Required response: ACK_O never asserts, outputs are 0 within the same cycle, and the memory word is unchanged.

Source files
------------

// File: rtl/wb_slave_pkg.sv
// Shared types and defaults for the Wishbone classic-cycle memory slave.
package wb_slave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_state_e;

   localparam int          DEF_ADR_WIDTH   = 32;
   localparam int          DEF_DAT_WIDTH   = 64;
   localparam int          DEF_TG_WIDTH    = 8;
   localparam int          DEF_MEM_DEPTH   = 256;
   localparam logic [63:0] DEF_BASE_ADDR   = 64'h0;
   localparam int          DEF_WAIT_STATES = 1;

   // Number of byte-offset bits inside one data word.
   function automatic int sel_log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/wb_slave_mem_array.sv
// Single-port byte-enable RAM: synchronous write, registered read.
module wb_slave_mem_array
   import wb_slave_pkg::*;
#(
   parameter int DAT_WIDTH = DEF_DAT_WIDTH,
   parameter int SEL_WIDTH = DAT_WIDTH / 8,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int IW        = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_we,
   input  logic                 i_re,
   input  logic [IW-1:0]        i_idx,
   input  logic [DAT_WIDTH-1:0] i_wdat,
   input  logic [SEL_WIDTH-1:0] i_sel,
   output logic [DAT_WIDTH-1:0] o_rdat
);

   logic [DAT_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [DAT_WIDTH-1:0] r_rdat;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < SEL_WIDTH; i++) begin
            if (i_sel[i]) r_mem[i_idx][8*i +: 8] <= i_wdat[8*i +: 8];
         end
      end
   end

   // The read register doubles as the bus DAT_O, so it is the only part reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_rdat <= '0;
      else if (i_re) r_rdat <= r_mem[i_idx];
   end

   assign o_rdat = r_rdat;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic-cycle memory slave with fixed, programmable wait states.
module wb_slave_mem
   import wb_slave_pkg::*;
#(
   parameter int          ADR_WIDTH   = DEF_ADR_WIDTH,
   parameter int          DAT_WIDTH   = DEF_DAT_WIDTH,
   parameter int          SEL_WIDTH   = DAT_WIDTH / 8,
   parameter int          TG_WIDTH    = DEF_TG_WIDTH,
   parameter int          MEM_DEPTH   = DEF_MEM_DEPTH,
   parameter logic [63:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   input  logic                 CYC_I,
   input  logic                 STB_I,
   input  logic                 WE_I,
   input  logic                 LOCK_I,
   input  logic [ADR_WIDTH-1:0] ADR_I,
   input  logic [DAT_WIDTH-1:0] DAT_I,
   input  logic [SEL_WIDTH-1:0] SEL_I,
   input  logic [TG_WIDTH-1:0]  TGA_I,
   input  logic [TG_WIDTH-1:0]  TGC_I,
   input  logic [TG_WIDTH-1:0]  TGD_I,
   output logic [DAT_WIDTH-1:0] DAT_O,
   output logic [TG_WIDTH-1:0]  TGD_O,
   output logic                 ACK_O,
   output logic                 ERR_O,
   output logic                 RTY_O
);

   localparam int          AW = sel_log2(SEL_WIDTH);
   localparam int          IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [63:0] LO = BASE_ADDR;
   localparam logic [63:0] HI = BASE_ADDR + 64'(MEM_DEPTH) * 64'(SEL_WIDTH);

   wb_state_e            r_state;
   logic [3:0]           r_cnt;
   logic                 r_we;
   logic [IW-1:0]        r_idx;
   logic [DAT_WIDTH-1:0] r_dat;
   logic [SEL_WIDTH-1:0] r_sel;
   logic [TG_WIDTH-1:0]  r_tgd;

   logic                 w_req, w_bad, w_fin, w_now, w_commit, w_idle;
   logic [63:0]          w_adr;
   logic [IW-1:0]        w_in_idx, w_idx;
   logic                 w_cur_we;
   logic [DAT_WIDTH-1:0] w_cur_dat;
   logic [SEL_WIDTH-1:0] w_cur_sel;
   logic                 w_unused;

   assign w_unused = ^{LOCK_I, TGA_I, TGC_I};
   assign RTY_O    = 1'b0;

   assign w_req    = CYC_I & STB_I;
   assign w_idle   = (r_state == IDLE);
   assign w_adr    = 64'(ADR_I);
   assign w_bad    = (w_adr < LO) | (w_adr >= HI) | ((w_adr & 64'(SEL_WIDTH - 1)) != 64'd0);
   assign w_in_idx = IW'((w_adr - LO) >> AW);

   // A good transfer completes on the edge that enters RESP; with zero wait
   // states that edge is the request edge itself, so the live bus is used.
   assign w_fin    = (r_state == WAIT) & w_req & (r_cnt == 4'd1);
   assign w_now    = w_idle & w_req & ~w_bad & (WAIT_STATES == 0);
   assign w_commit = w_fin | w_now;

   assign w_idx     = w_idle ? w_in_idx : r_idx;
   assign w_cur_we  = w_idle ? WE_I     : r_we;
   assign w_cur_dat = w_idle ? DAT_I    : r_dat;
   assign w_cur_sel = w_idle ? SEL_I    : r_sel;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_dat   <= '0;
         r_sel   <= '0;
         r_tgd   <= '0;
         ACK_O   <= 1'b0;
         ERR_O   <= 1'b0;
         TGD_O   <= '0;
      end else begin
         ACK_O <= 1'b0;
         ERR_O <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_we  <= WE_I;
                  r_idx <= w_in_idx;
                  r_dat <= DAT_I;
                  r_sel <= SEL_I;
                  r_tgd <= TGD_I;
                  if (w_bad) begin
                     r_state <= RESP;
                     ERR_O   <= 1'b1;
                     TGD_O   <= TGD_I;
                  end else if (WAIT_STATES == 0) begin
                     r_state <= RESP;
                     ACK_O   <= 1'b1;
                     TGD_O   <= TGD_I;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= 4'(WAIT_STATES);
                  end
               end
            end
            WAIT: begin
               if (!w_req) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == 4'd1) begin
                  r_state <= RESP;
                  r_cnt   <= '0;
                  ACK_O   <= 1'b1;
                  TGD_O   <= r_tgd;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   wb_slave_mem_array #(
      .DAT_WIDTH (DAT_WIDTH),
      .SEL_WIDTH (SEL_WIDTH),
      .MEM_DEPTH (MEM_DEPTH),
      .IW        (IW)
   ) u_mem (
      .i_clk  (CLK_I),
      .i_rst  (RST_I),
      .i_we   (w_commit & w_cur_we & ~RST_I),
      .i_re   (w_commit & ~w_cur_we),
      .i_idx  (w_idx),
      .i_wdat (w_cur_dat),
      .i_sel  (w_cur_sel),
      .o_rdat (DAT_O)
   );

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: two instances (1 and 3 wait states) against a word-array model.
module tb_wb_slave_mem;

   logic              clk;
   logic [1:0]        rst, cyc, stb, we, lock;
   logic [1:0][31:0]  adr;
   logic [1:0][63:0]  dat_i, dato;
   logic [1:0][7:0]   sel, tga, tgc, tgd_i, tgo;
   logic [1:0]        ack, err, rty;

   logic [63:0] mdl [2][256];
   logic [63:0] last_dat [2];
   int checks, failures;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      logic [7:0]  tg;
      logic        e_err;
      logic [63:0] e_dat;
   } vec_t;
   vec_t tbl [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_slave_mem #(.WAIT_STATES(1)) dut0 (
      .CLK_I(clk), .RST_I(rst[0]), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]),
      .LOCK_I(lock[0]), .ADR_I(adr[0]), .DAT_I(dat_i[0]), .SEL_I(sel[0]),
      .TGA_I(tga[0]), .TGC_I(tgc[0]), .TGD_I(tgd_i[0]), .DAT_O(dato[0]),
      .TGD_O(tgo[0]), .ACK_O(ack[0]), .ERR_O(err[0]), .RTY_O(rty[0]));

   wb_slave_mem #(.WAIT_STATES(3)) dut1 (
      .CLK_I(clk), .RST_I(rst[1]), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]),
      .LOCK_I(lock[1]), .ADR_I(adr[1]), .DAT_I(dat_i[1]), .SEL_I(sel[1]),
      .TGA_I(tga[1]), .TGC_I(tgc[1]), .TGD_I(tgd_i[1]), .DAT_O(dato[1]),
      .TGD_O(tgo[1]), .ACK_O(ack[1]), .ERR_O(err[1]), .RTY_O(rty[1]));

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // One transfer from a negedge; returns at the negedge of the following idle cycle.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [63:0] dt,
                       input logic [7:0] s, input logic [7:0] tg,
                       output logic got_err, output logic [63:0] got_dat);
      logic bad;
      int   lat, k, wi;
      bad = (a >= 32'h800) || (a[2:0] != 3'd0);
      wi  = int'(a >> 3) & 255;
      lat = bad ? 1 : ws_of(d) + 1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a;
      dat_i[d] = dt; sel[d] = s; tgd_i[d] = tg;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(ack[d] | err[d]) && k < 20);
      got_err = err[d];
      got_dat = dato[d];
      cyc[d] = 1'b0; stb[d] = 1'b0;
      if (!bad && !w) last_dat[d] = mdl[d][wi];
      if (!bad && w)
         for (int b = 0; b < 8; b++) if (s[b]) mdl[d][wi][8*b +: 8] = dt[8*b +: 8];
      check($sformatf("d%0d lat a=%h", d, a), 64'(k), 64'(lat));
      check($sformatf("d%0d ack_err a=%h", d, a), {62'd0, ack[d], err[d]}, bad ? 64'd1 : 64'd2);
      check($sformatf("d%0d tgd a=%h", d, a), 64'(tgo[d]), 64'(tg));
      check($sformatf("d%0d dat a=%h", d, a), dato[d], last_dat[d]);
      @(negedge clk);
      check($sformatf("d%0d pulse a=%h", d, a), {62'd0, ack[d], err[d]}, 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ge, seen;
      logic [63:0] gd, nd, old;
      logic [31:0] a;
      int          r;
      checks = 0; failures = 0;
      rst = 2'b11; cyc = 2'b11; stb = 2'b00; we = '0; lock = '0;
      adr = '0; dat_i = '0; sel = '0; tga = '0; tgc = '0; tgd_i = '0;
      last_dat[0] = '0; last_dat[1] = '0;

      // Reset held 3 cycles; CYC high with STB low must draw no response.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 2'b00;
      repeat (3) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d rst_dat", d), dato[d], 64'd0);
            check($sformatf("d%0d rst_ctl", d), {53'd0, ack[d], err[d], rty[d], tgo[d]}, 64'd0);
         end
      end
      cyc = 2'b00;

      // Directed vectors on the 1-wait-state instance.
      tbl[0] = '{1'b1, 32'h10,  64'h1122334455667788, 8'hFF, 8'h5A, 1'b0, 64'h0};
      tbl[1] = '{1'b0, 32'h10,  64'h0,                8'hFF, 8'h5A, 1'b0, 64'h1122334455667788};
      tbl[2] = '{1'b1, 32'h10,  64'hFFFFFFFFFFFFFFFF, 8'h0F, 8'h5A, 1'b0, 64'h1122334455667788};
      tbl[3] = '{1'b0, 32'h10,  64'h0,                8'h00, 8'h5A, 1'b0, 64'h11223344FFFFFFFF};
      tbl[4] = '{1'b1, 32'h13,  64'h0123456789ABCDEF, 8'hFF, 8'h77, 1'b1, 64'h11223344FFFFFFFF};
      tbl[5] = '{1'b1, 32'h800, 64'hDEADBEEFDEADBEEF, 8'hFF, 8'hA5, 1'b1, 64'h11223344FFFFFFFF};
      tbl[6] = '{1'b1, 32'h810, 64'hDEADBEEFDEADBEEF, 8'hFF, 8'hA6, 1'b1, 64'h11223344FFFFFFFF};
      tbl[7] = '{1'b0, 32'h10,  64'h0,                8'hFF, 8'h3C, 1'b0, 64'h11223344FFFFFFFF};
      tbl[8] = '{1'b0, 32'hFFFFFFF8, 64'h0,           8'hFF, 8'hC3, 1'b1, 64'h11223344FFFFFFFF};
      tbl[9] = '{1'b0, 32'h7FF, 64'h0,                8'hFF, 8'h01, 1'b1, 64'h11223344FFFFFFFF};
      for (int i = 0; i < 10; i++) begin
         xfer(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].tg, ge, gd);
         check($sformatf("tbl%0d err", i), {63'd0, ge}, {63'd0, tbl[i].e_err});
         check($sformatf("tbl%0d dat", i), gd, tbl[i].e_dat);
      end

      // Fill words 0..15 of both instances (word 2 of dut0 keeps its directed value).
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++)
            if (!(d == 0 && w == 2))
               xfer(d, 1'b1, 32'(w << 3), {$urandom, $urandom}, 8'hFF, 8'($urandom), ge, gd);

      // Abort: drop CYC in the second wait cycle of a write to 0x20.
      old = mdl[1][4];
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20;
      dat_i[1] = ~old; sel[1] = 8'hFF; tgd_i[1] = 8'h44;
      @(negedge clk);
      @(negedge clk);
      cyc[1] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      stb[1] = 1'b0;
      check("abort no_resp", {63'd0, seen}, 64'd0);
      xfer(1, 1'b0, 32'h20, 64'h0, 8'hFF, 8'h45, ge, gd);
      check("abort old_data", gd, old);

      // Held read strobe: each new transfer every WAIT_STATES+2 = 5 cycles.
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h18; tgd_i[1] = 8'h99;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         check($sformatf("b2b ack k=%0d", k), {63'd0, ack[1]}, {63'd0, (k % 5) == 4});
         if (ack[1]) check($sformatf("b2b dat k=%0d", k), dato[1], mdl[1][3]);
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      last_dat[1] = mdl[1][3];
      @(negedge clk);

      // Reset during WAIT of a write: outputs clear at once, word 5 untouched.
      xfer(1, 1'b0, 32'h18, 64'h0, 8'hFF, 8'h5C, ge, gd);
      old = mdl[1][5];
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h28;
      dat_i[1] = ~old; sel[1] = 8'hFF; tgd_i[1] = 8'h66;
      @(negedge clk);
      @(negedge clk);
      #2 rst[1] = 1'b1;
      #1;
      check("midrst dat", dato[1], 64'd0);
      check("midrst ctl", {53'd0, ack[1], err[1], rty[1], tgo[1]}, 64'd0);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      rst[1] = 1'b0;
      last_dat[1] = '0;
      @(negedge clk);
      check("midrst no_resp", {63'd0, seen}, 64'd0);
      xfer(1, 1'b0, 32'h28, 64'h0, 8'hFF, 8'h67, ge, gd);
      check("midrst old_data", gd, old);

      // Randomized traffic against the model.
      for (int d = 0; d < 2; d++) begin
         repeat (40) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = 32'h800 + 32'($urandom_range(0, 255) << 3);
            else if (r == 1) a = 32'($urandom_range(0, 15) << 3) | 32'($urandom_range(1, 7));
            else             a = 32'($urandom_range(0, 15) << 3);
            nd = {$urandom, $urandom};
            xfer(d, 1'($urandom), a, nd, 8'($urandom), 8'($urandom), ge, gd);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
